// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised pipeline-stage register with a valid/ready
// handshake. A main register plus a one-entry skid register sustain one word
// per cycle while in_ready comes from a flop. Stall holds the stage and
// flush kills every held entry. Control is masked to zero whenever
// out_valid is low, so a bubble never carries reg_wr/mem_wr.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall and flush
// counters on the stall_cnt and flush_cnt ports.
module pipe_stage_hs #(
    parameter int unsigned DATA_W = 140,
    parameter int unsigned CTRL_W = 17
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              m_v, m_v_n;
    logic [DATA_W-1:0] m_d, m_d_n;
    logic [CTRL_W-1:0] m_c, m_c_n;
    logic              s_v, s_v_n;
    logic [DATA_W-1:0] s_d, s_d_n;
    logic [CTRL_W-1:0] s_c, s_c_n;
    logic              rdy_q, rdy_n;
    logic              enq;
    logic              deq;

    // Handshake: the ready flop is gated by stall; a stalled or flushed
    // stage shows a bubble downstream.
    assign in_ready  = rdy_q & ~stall;
    assign out_valid = m_v & ~stall & ~flush;
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign out_data  = m_d;
    assign out_ctrl  = out_valid ? m_c : '0;

    // Next state for the main/skid pair; the skid always drains into main first.
    always_comb begin
        m_v_n = m_v;
        m_d_n = m_d;
        m_c_n = m_c;
        s_v_n = s_v;
        s_d_n = s_d;
        s_c_n = s_c;
        if (flush) begin
            m_v_n = 1'b0;
            s_v_n = 1'b0;
        end else if (!stall) begin
            if (!m_v || deq) begin
                if (s_v) begin
                    m_v_n = 1'b1;
                    m_d_n = s_d;
                    m_c_n = s_c;
                    s_v_n = enq;
                    if (enq) begin
                        s_d_n = in_data;
                        s_c_n = in_ctrl;
                    end
                end else begin
                    m_v_n = enq;
                    if (enq) begin
                        m_d_n = in_data;
                        m_c_n = in_ctrl;
                    end
                end
            end else if (enq) begin
                s_v_n = 1'b1;
                s_d_n = in_data;
                s_c_n = in_ctrl;
            end
        end
        rdy_n = ~s_v_n;
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v   <= 1'b0;
            m_d   <= '0;
            m_c   <= '0;
            s_v   <= 1'b0;
            s_d   <= '0;
            s_c   <= '0;
            rdy_q <= 1'b0;
        end else begin
            m_v   <= m_v_n;
            m_d   <= m_d_n;
            m_c   <= m_c_n;
            s_v   <= s_v_n;
            s_d   <= s_d_n;
            s_c   <= s_c_n;
            rdy_q <= rdy_n;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt} + SUM_W'(m_v) + SUM_W'(s_v);

    // Saturating counts of stalled cycles and of entries killed by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a queue-based reference of the stage contents,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_hs;

    localparam int unsigned DATA_W = 140;
    localparam int unsigned CTRL_W = 17;
`ifdef PIPE_PERF_CNT_EN
    localparam int unsigned CNT_W  = 16;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_stage_hs dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: ordered contents of the stage (front = word on the output).
    logic [DATA_W-1:0] qd[$];
    logic [CTRL_W-1:0] qc[$];
    bit                m_rdy;
    int                m_stall_cnt;
    int                m_flush_cnt;

    // Values seen on the DUT during the most recent step.
    logic              obs_in_ready;
    logic              obs_out_valid;
    logic [DATA_W-1:0] obs_data;
    logic [CTRL_W-1:0] obs_ctrl;

    function automatic logic [DATA_W-1:0] w(input int v);
        return DATA_W'(v);
    endfunction

    function automatic logic [CTRL_W-1:0] cw(input int v);
        return CTRL_W'(v);
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qd.delete();
        qc.delete();
        m_rdy       = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // One clock cycle: drive, compare against the reference, advance it.
    task automatic step(input bit rn, input bit st, input bit fl, input bit iv, input bit orr,
                        input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        bit                e_in_ready;
        bit                e_out_valid;
        bit                do_enq;
        bit                do_deq;
        logic [CTRL_W-1:0] e_ctrl;
        @(negedge clk);
        reset_n   = rn;
        stall     = st;
        flush     = fl;
        in_valid  = iv;
        out_ready = orr;
        in_data   = d;
        in_ctrl   = c;
        #1;
        if (!rn) model_reset();
        e_in_ready  = m_rdy && !st;
        e_out_valid = (qd.size() > 0) && !st && !fl;
        e_ctrl      = '0;
        if (e_out_valid) e_ctrl = qc[0];
        chk("in_ready", DATA_W'(in_ready), DATA_W'(e_in_ready));
        chk("out_valid", DATA_W'(out_valid), DATA_W'(e_out_valid));
        chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(e_ctrl));
        if (!rn) chk("out_data_reset", out_data, '0);
        else if (qd.size() > 0) chk("out_data", out_data, qd[0]);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall_cnt));
        chk("flush_cnt", DATA_W'(flush_cnt), DATA_W'(m_flush_cnt));
`endif
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_data      = out_data;
        obs_ctrl      = out_ctrl;
        do_enq = iv && e_in_ready;
        do_deq = e_out_valid && orr;
        @(posedge clk);
        if (rn) begin
            if (st) m_stall_cnt = (m_stall_cnt >= 65535) ? 65535 : m_stall_cnt + 1;
            if (fl) begin
                m_flush_cnt = m_flush_cnt + qd.size();
                if (m_flush_cnt > 65535) m_flush_cnt = 65535;
                qd.delete();
                qc.delete();
            end else if (!st) begin
                if (do_deq) begin
                    void'(qd.pop_front());
                    void'(qc.pop_front());
                end
                if (do_enq) begin
                    qd.push_back(d);
                    qc.push_back(c);
                end
            end
            m_rdy = (qd.size() < 2);
        end
    endtask

    task automatic idle(input bit orr);
        step(1'b1, 1'b0, 1'b0, 1'b0, orr, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        model_reset();

        // Reset state, then first cycle after release.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w(5), cw(5));
        chk("rst_in_ready", DATA_W'(obs_in_ready), w(0));
        chk("rst_out_valid", DATA_W'(obs_out_valid), w(0));
        chk("rst_out_data", obs_data, w(0));
        idle(1'b1);
        idle(1'b1);
        chk("release_in_ready", DATA_W'(obs_in_ready), w(1));

        // T2: back-to-back words with out_ready high.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w(1), cw(1));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w(2), cw(2));
        chk("t2_a", obs_data, w(1));
        chk("t2_a_ctrl", DATA_W'(obs_ctrl), w(1));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w(3), cw(3));
        chk("t2_b", obs_data, w(2));
        chk("t2_ready", DATA_W'(obs_in_ready), w(1));
        idle(1'b1);
        chk("t2_c", obs_data, w(3));
        chk("t2_c_valid", DATA_W'(obs_out_valid), w(1));
        idle(1'b1);

        // T3: fill main and skid, then drain in order.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h1A), cw('h1A));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h1B), cw('h1B));
        idle(1'b0);
        chk("t3_full_ready", DATA_W'(obs_in_ready), w(0));
        chk("t3_head", obs_data, w('h1A));
        idle(1'b1);
        chk("t3_out_a", obs_data, w('h1A));
        idle(1'b1);
        chk("t3_out_b", obs_data, w('h1B));
        chk("t3_ready_back", DATA_W'(obs_in_ready), w(1));
        idle(1'b1);

        // T1: reset while both entries are held.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h21), cw('h1F));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h22), cw('h1F));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w('h23), cw('h1F));
        chk("t1_valid", DATA_W'(obs_out_valid), w(0));
        chk("t1_ctrl", DATA_W'(obs_ctrl), w(0));
        idle(1'b1);
        idle(1'b1);
        chk("t1_ready", DATA_W'(obs_in_ready), w(1));

        // T4: stall for three cycles with a held word and a waiting input.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h4A), cw('h4A));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, w('h77), cw('h77));
            chk("t4_stall_valid", DATA_W'(obs_out_valid), w(0));
            chk("t4_stall_ctrl", DATA_W'(obs_ctrl), w(0));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w('h77), cw('h77));
        chk("t4_out_a", obs_data, w('h4A));
`ifdef PIPE_PERF_CNT_EN
        chk("t4_stall_cnt", DATA_W'(stall_cnt), w(3));
`endif
        idle(1'b1);
        chk("t4_out_in", obs_data, w('h77));
        idle(1'b1);

        // T5: flush together with stall while full.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h51), cw('h51));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w('h52), cw('h52));
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, w('hEE), cw('hEE));
        chk("t5_flush_valid", DATA_W'(obs_out_valid), w(0));
        idle(1'b1);
        chk("t5_after_valid", DATA_W'(obs_out_valid), w(0));
`ifdef PIPE_PERF_CNT_EN
        chk("t5_flush_cnt", DATA_W'(flush_cnt), w(2));
`endif
        idle(1'b1);

        // T6: all-ones control with toggling stall and no drain.
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'(i % 2), 1'b0, 1'b1, 1'b0, w(i), '1);
            if (!obs_out_valid) chk("t6_ctrl_mask", DATA_W'(obs_ctrl), w(0));
        end
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rn;
            bit st;
            bit fl;
            bit iv;
            bit orr;
            rn  = ($urandom_range(0, 299) != 0);
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            step(rn, st, fl, iv, orr,
                 DATA_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
                 CTRL_W'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
